multdiv: RTL and testbench
==========================

# multdiv

Iterative signed 32-bit multiply/divide unit in the execute stage, beside `alu`. It takes the same operand bus as `alu` (`data_operandA`, `data_operandB`). Writeback selects its `data_result` in place of the ALU result for MUL/DIV instructions. The pipeline stalls while `data_resultRDY` is pending.

## Interface
- `WIDTH`, 32: operand/result width; only 32 is supported.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `data_operandA`  in  32  signed multiplicand / dividend.
- `data_operandB`  in  32  signed multiplier / divisor.
- `ctrl_MULT`  in  1  one-cycle start pulse for multiply.
- `ctrl_DIV`  in  1  one-cycle start pulse for divide.
- `data_result`  out  32  signed result; held until the next start.
- `data_exception`  out  1  overflow or divide-by-zero for the current result; held with `data_result`.
- `data_resultRDY`  out  1  one-cycle pulse: result and exception are valid.
- `busy`  out  1  an operation is in flight.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Start handling:
  - At a clock edge with `ctrl_MULT` or `ctrl_DIV` high, latch both operands and clear the iteration counter (6-bit).
  - Next state is MUL or DIV.
  - Starts are accepted in any state, so a start while busy aborts the current operation and restarts.
  - `ctrl_MULT` and `ctrl_DIV` both high: MULT wins.
- MUL:
  - Magnitudes |A| and |B| feed a 32-iteration unsigned shift-add into a 64-bit accumulator.
  - Apply the sign A[31]^B[31] at completion.
  - `data_result` = product[31:0].
  - `data_exception` = 1 if the 64-bit signed product is outside [-2^31, 2^31-1].
- DIV:
  - Magnitudes feed a 32-iteration restoring divide, one quotient bit per cycle.
  - Quotient truncates toward zero: negate if A[31]^B[31]. Remainder is discarded.
  - B == 0: `data_result` = 0, `data_exception` = 1.
  - A == 0x80000000 and B == 0xFFFFFFFF: `data_result` = 0, `data_exception` = 1.
  - Special cases still take the full latency.
- |0x80000000| is handled as unsigned 0x80000000 in a 33-bit magnitude path.
- After 32 iterations: go to DONE, load the result and exception registers, pulse `data_resultRDY`, then return to IDLE.
- Unless a start arrives, `data_result` and `data_exception` hold their last values until the next completion.
- `busy` = state is MUL or DIV.

## Timing
- Reset (async assert, sync release):
  - state IDLE.
  - `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0, `busy` = 0.
  - Counter and accumulators cleared.
- Latency:
  - Start sampled at edge E0.
  - `busy` = 1 from E0 through E32.
  - `data_resultRDY` = 1 for exactly the cycle after E33, together with the final `data_result` and `data_exception`.
  - Fixed 33 cycles for every operand value and both operations.
- Throughput:
  - A new start may be sampled in the same cycle `data_resultRDY` is high; that completion still reports.
  - A start sampled while `busy` suppresses the in-flight completion: no `data_resultRDY` pulse for the aborted operation.
- Operands need only be valid in the start cycle.
- Reset mid-operation: immediate return to reset values; no `data_resultRDY`.

## Structure
- Shared package `cpu_pkg`:
  - ALU opcode constants (ADD=0, SUB=1, AND=2, OR=3, SLL=4, SRA=5, MUL=6, DIV=7).
  - `md_state_t` enum {IDLE, MUL, DIV, DONE}.
  - `MD_ITERS` = 32.
- One sub-module: `div_step`, combinational. It takes the remainder, next dividend bit and divisor, and returns the new remainder and quotient bit.
- The multiply step stays inline.

## Test plan
- `ctrl_MULT` with A=6, B=7 -> after 33 cycles `data_resultRDY` pulse, `data_result`=42, `data_exception`=0; `busy` is low the cycle after the pulse.
- MULT with A=-3, B=0x10000 -> `data_result`=0xFFFD0000, exception 0. MULT with A=0x10000, B=0x10000 -> `data_result`=0, exception 1.
- DIV with A=-7, B=2 -> `data_result`=0xFFFFFFFD (-3), exception 0. DIV with A=5, B=0 -> `data_result`=0, exception 1, still 33 cycles.
- DIV with A=0x80000000, B=-1 -> `data_result`=0, exception 1. DIV with A=0x80000000, B=2 -> 0xC0000000, exception 0.
- MULT 6*7, then DIV 100/7 at cycle 10 -> exactly one `data_resultRDY`, 33 cycles after the DIV start, with `data_result`=14.
- Assert `reset_n` low at cycle 15 of a MULT -> all outputs 0 asynchronously; no `data_resultRDY` after release; the next MULT 2*3 returns 6.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: ALU opcodes, multdiv FSM states and
// the operand magnitude helper used by the iterative multiply/divide unit.
package cpu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLL = 3'd4;
    localparam logic [2:0] ALU_SRA = 3'd5;
    localparam logic [2:0] ALU_MUL = 3'd6;
    localparam logic [2:0] ALU_DIV = 3'd7;

    localparam int MD_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    // 33 bits so that |0x80000000| = 0x0_8000_0000 is representable.
    function automatic logic [32:0] mag33(input logic [31:0] v);
        return v[31] ? (33'd0 - {v[31], v}) : {1'b0, v};
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract
// the divisor when it fits, and emit the resulting quotient bit.
module div_step (
    input  logic [32:0] rem_in,
    input  logic        dvd_bit,
    input  logic [32:0] divisor,
    output logic [32:0] rem_out,
    output logic        q_bit
);

    logic [33:0] shifted;
    logic [32:0] diff;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        q_bit   = (shifted >= {1'b0, divisor});
        // The difference is only kept when it fits, so 33 bits are enough.
        diff    = shifted[32:0] - divisor;
        rem_out = q_bit ? diff : shifted[32:0];
    end

endmodule

// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply/divide unit: fixed 33-cycle latency,
// shift-add multiply and restoring divide on operand magnitudes.
module multdiv
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [5:0] ITERS = 6'(MD_ITERS);

    md_state_t   state, state_next;
    logic [5:0]  cnt;
    logic        neg;
    logic        div_special;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [32:0] mplier;
    logic [32:0] rem;
    logic [32:0] divisor;
    logic [31:0] dvd;
    logic [31:0] quo;

    logic        start;
    logic [32:0] mag_a, mag_b;
    logic [63:0] prod_signed;
    logic [32:0] prod_hi;
    logic        mul_ovf;
    logic [31:0] quo_signed;
    logic [32:0] rem_next;
    logic        q_bit;

    assign start = ctrl_MULT | ctrl_DIV;
    assign mag_a = mag33(data_operandA);
    assign mag_b = mag33(data_operandB);

    assign prod_signed = neg ? (64'd0 - acc) : acc;
    assign prod_hi     = prod_signed[63:31];
    assign mul_ovf     = ~((&prod_hi) | ~(|prod_hi));
    assign quo_signed  = neg ? (32'd0 - quo) : quo;

    div_step u_div_step (
        .rem_in  (rem),
        .dvd_bit (dvd[31]),
        .divisor (divisor),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: next state defaults to the current state first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        if (ctrl_MULT) begin
            state_next = MUL;
        end else if (ctrl_DIV) begin
            state_next = DIV;
        end else begin
            case (state)
                MUL:     if (cnt == ITERS) state_next = DONE;
                DIV:     if (cnt == ITERS) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            neg            <= 1'b0;
            div_special    <= 1'b0;
            acc            <= '0;
            mcand          <= '0;
            mplier         <= '0;
            rem            <= '0;
            divisor        <= '0;
            dvd            <= '0;
            quo            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            // A start always wins, aborting any in-flight completion.
            cnt         <= '0;
            neg         <= data_operandA[31] ^ data_operandB[31];
            div_special <= (data_operandB == 32'd0) ||
                           (data_operandA == 32'h8000_0000 && data_operandB == 32'hFFFF_FFFF);
            acc         <= '0;
            mcand       <= {31'd0, mag_a};
            mplier      <= mag_b;
            rem         <= '0;
            divisor     <= mag_b;
            dvd         <= mag_a[31:0];
            quo         <= '0;
        end else if (state == MUL) begin
            if (cnt == ITERS) begin
                data_result    <= prod_signed[31:0];
                data_exception <= mul_ovf;
            end else begin
                acc    <= acc + (mplier[0] ? mcand : 64'd0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 6'd1;
            end
        end else if (state == DIV) begin
            if (cnt == ITERS) begin
                data_result    <= div_special ? 32'd0 : quo_signed;
                data_exception <= div_special;
            end else begin
                rem <= rem_next;
                dvd <= dvd << 1;
                quo <= {quo[30:0], q_bit};
                cnt <= cnt + 6'd1;
            end
        end
    end

    assign data_resultRDY = (state == DONE);
    assign busy           = (state == MUL) || (state == DIV);

endmodule

// File: tb/tb_multdiv.sv
// Directed self-checking bench for multdiv: vector table plus abort and
// mid-operation reset sequences.
module tb_multdiv;

    logic        clock;
    logic        reset_n;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    multdiv #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        is_mul;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic is_mul, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = is_mul;
        ctrl_DIV      = ~is_mul;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h1234_5678;
    endtask

    // n = negedge index after the start edge at which RDY was seen (0 = timeout).
    task automatic wait_rdy(output int n, output logic [31:0] res, output logic exc,
                            output logic busy_first);
        n = 0;
        res = '0;
        exc = 1'b0;
        busy_first = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i == 1) busy_first = busy;
            if (data_resultRDY) begin
                n   = i;
                res = data_result;
                exc = data_exception;
                return;
            end
        end
    endtask

    initial begin
        int          n;
        logic [31:0] res;
        logic        exc;
        logic        bf;
        int          pulses;
        int          first_n;
        logic [31:0] pulse_res;
        logic        pulse_exc;

        vecs[0]  = '{1'b1, 32'd6,          32'd7,          32'd42,         1'b0};
        vecs[1]  = '{1'b1, 32'hFFFF_FFFD,  32'h0001_0000,  32'hFFFD_0000,  1'b0};
        vecs[2]  = '{1'b1, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000,  1'b1};
        vecs[3]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
        vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'd0,          1'b1};
        vecs[5]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
        vecs[6]  = '{1'b0, 32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0};
        vecs[7]  = '{1'b0, 32'd100,        32'd7,          32'd14,         1'b0};
        vecs[8]  = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0};
        vecs[9]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
        vecs[10] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0};
        vecs[11] = '{1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
        vecs[12] = '{1'b1, 32'h7FFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b1};

        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #12;
        check("reset_result", 64'(data_result), 64'd0);
        check("reset_exc",    64'(data_exception), 64'd0);
        check("reset_rdy",    64'(data_resultRDY), 64'd0);
        check("reset_busy",   64'(busy), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[k]) begin
            do_start(vecs[k].is_mul, vecs[k].a, vecs[k].b);
            wait_rdy(n, res, exc, bf);
            check($sformatf("v%0d_busy_first", k), 64'(bf), 64'd1);
            check($sformatf("v%0d_latency", k), 64'(n), 64'd34);
            check($sformatf("v%0d_result", k), 64'(res), 64'(vecs[k].res));
            check($sformatf("v%0d_exc", k), 64'(exc), 64'(vecs[k].exc));
            @(negedge clock);
            check($sformatf("v%0d_rdy_after", k), 64'(data_resultRDY), 64'd0);
            check($sformatf("v%0d_busy_after", k), 64'(busy), 64'd0);
            check($sformatf("v%0d_result_held", k), 64'(data_result), 64'(vecs[k].res));
        end

        // Abort: MULT 6*7, then DIV 100/7 started at cycle 10.
        do_start(1'b1, 32'd6, 32'd7);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            check($sformatf("abort_no_rdy_%0d", i), 64'(data_resultRDY), 64'd0);
        end
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        pulses    = 0;
        first_n   = 0;
        pulse_res = '0;
        pulse_exc = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                pulses++;
                if (first_n == 0) begin
                    first_n   = i;
                    pulse_res = data_result;
                    pulse_exc = data_exception;
                end
            end
        end
        check("abort_pulses",  64'(pulses), 64'd1);
        check("abort_latency", 64'(first_n), 64'd34);
        check("abort_result",  64'(pulse_res), 64'd14);
        check("abort_exc",     64'(pulse_exc), 64'd0);

        // Reset in the middle of a multiply.
        do_start(1'b1, 32'd6, 32'd7);
        for (int i = 1; i <= 15; i++) @(negedge clock);
        check("midrst_busy_before", 64'(busy), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_result", 64'(data_result), 64'd0);
        check("midrst_exc",    64'(data_exception), 64'd0);
        check("midrst_rdy",    64'(data_resultRDY), 64'd0);
        check("midrst_busy",   64'(busy), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) pulses++;
        end
        check("midrst_no_rdy", 64'(pulses), 64'd0);
        do_start(1'b1, 32'd2, 32'd3);
        wait_rdy(n, res, exc, bf);
        check("post_rst_latency", 64'(n), 64'd34);
        check("post_rst_result",  64'(res), 64'd6);
        check("post_rst_exc",     64'(exc), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
